// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-subset datapath with a sticky illegal-instruction flag.
// Defining MULTICYCLE_CTRL_PERF_EN adds cycle and retired-instruction counters (cyc_cnt, ret_cnt).
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [2:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             pcen,
    output logic             illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_IMMEX, S_IMMWB, S_JEX
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   r_isStore;
    logic   w_setIllegal;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_isStore <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_setIllegal)
                r_illegal <= 1'b1;
            // Op is only valid in DECODE, so remember lw/sw for the MEMADR decision.
            if (r_state == S_DECODE)
                r_isStore <= (op == OP_SW);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_setIllegal = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        mem_req      = 1'b0;
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 3'b000;
        pcsrc        = 2'b00;
        alucontrol   = 3'b000;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = 3'b001;
                alucontrol = 3'b010;
                if (mem_ack) begin
                    irwrite   = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb    = 3'b011;
                alucontrol = 3'b010;
                case (op)
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_RTYP:          w_next = S_RTYPEEX;
                    OP_BEQ:           w_next = S_BEQEX;
                    OP_ADDI, OP_ORI:  w_next = S_IMMEX;
                    OP_J:             w_next = S_JEX;
                    default: begin
                        w_next       = S_FETCH;
                        w_setIllegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = 3'b010;
                w_next     = r_isStore ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ack)
                    w_next = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_next  = S_RTYPEWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        alucontrol   = 3'b010;
                        w_setIllegal = 1'b1;
                    end
                endcase
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
                w_next     = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                w_next  = S_IMMWB;
                if (op == OP_ORI) begin
                    alusrcb    = 3'b100;
                    alucontrol = 3'b001;
                end else begin
                    alusrcb    = 3'b010;
                    alucontrol = 3'b010;
                end
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign pcen    = w_pcwrite | (w_branch & zero);
    assign illegal = r_illegal;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic w_retire;

    // An instruction retires when a completing state hands control back to FETCH.
    always_comb begin
        w_retire = 1'b0;
        if (w_next == S_FETCH) begin
            case (r_state)
                S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX: w_retire = 1'b1;
                default: w_retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (w_retire)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction scenarios plus random instruction mixes.
// The reference model expands each instruction into its expected per-cycle control vectors.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [2:0] alusrcb, alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CW-1:0] cyc_cnt, ret_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cycModel = 0;
    int retModel = 0;
    bit illModel = 1'b0;

    logic [5:0] legalFunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    logic [17:0] obsVec;
    assign obsVec = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, alucontrol, pcen, illegal};

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
        .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    // Order: mem_req iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc alucontrol pcen
    function automatic logic [16:0] ov(bit mreq, bit io, bit mw, bit irw, bit rd, bit mtr, bit rw,
                                       bit asa, logic [2:0] asb, logic [1:0] pcs,
                                       logic [2:0] alu, bit pce);
        return {mreq, io, mw, irw, rd, mtr, rw, asa, asb, pcs, alu, pce};
    endfunction

    function automatic bit isLegalOp(logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    endfunction

    // Returns {bad, alucontrol} from the R-type funct table.
    function automatic logic [3:0] functAlu(logic [5:0] f);
        case (f)
            6'b100000: return 4'b0_010;
            6'b100010: return 4'b0_110;
            6'b100100: return 4'b0_000;
            6'b100101: return 4'b0_001;
            6'b101010: return 4'b0_111;
            default:   return 4'b1_010;
        endcase
    endfunction

    task automatic applyStimulus(input bit ack, input bit z, input logic [5:0] o, input logic [5:0] f);
        mem_ack = ack;
        zero    = z;
        op      = o;
        funct   = f;
    endtask

    task automatic checkCounters(input string tag);
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        assert (cyc_cnt === cycModel[CW-1:0]) else begin
            errors++;
            $error("[TB] FAIL %s.cyc observed=%0d expected=%0d", tag, cyc_cnt, cycModel[CW-1:0]);
        end
        checks++;
        assert (ret_cnt === retModel[CW-1:0]) else begin
            errors++;
            $error("[TB] FAIL %s.ret observed=%0d expected=%0d", tag, ret_cnt, retModel[CW-1:0]);
        end
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    // Compares one cycle at the falling edge, then advances to just after the next rising edge.
    task automatic checkOutput(input string tag, input logic [16:0] e);
        logic [17:0] ex;
        @(negedge clk);
        ex = {e, illModel};
        checks++;
        assert (obsVec === ex) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obsVec, ex);
        end
        checkCounters(tag);
        @(posedge clk);
        #1;
        cycModel++;
    endtask

    // cls: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 ori, 6 j, 7 op=111111, 8 random illegal op
    // zsel: 0/1 force zero in BEQEX, else random. fsel: >=0 exact funct, -1 legal random, -2 any.
    task automatic runInstr(input int cls, input int fw, input int mw, input int zsel, input int fsel);
        logic [5:0] o, f;
        logic [3:0] fa;
        bit z;
        case (cls)
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: o = 6'b000000;
            3: o = 6'b000100;
            4: o = 6'b001000;
            5: o = 6'b001101;
            6: o = 6'b000010;
            7: o = 6'b111111;
            default: begin
                o = rnd6();
                while (isLegalOp(o)) o = rnd6();
            end
        endcase
        if (fsel >= 0) f = 6'(fsel);
        else if (fsel == -1) f = legalFunct[$urandom_range(0, 4)];
        else f = rnd6();

        for (int k = 0; k < fw; k++) begin
            applyStimulus(1'b0, rb(), rnd6(), rnd6());
            checkOutput("fetchWait", ov(1,0,0,0,0,0,0,0,3'b001,2'b00,3'b010,0));
        end
        applyStimulus(1'b1, rb(), rnd6(), rnd6());
        checkOutput("fetchAck", ov(1,0,0,1,0,0,0,0,3'b001,2'b00,3'b010,1));
        applyStimulus(rb(), rb(), o, rnd6());
        checkOutput("decode", ov(0,0,0,0,0,0,0,0,3'b011,2'b00,3'b010,0));

        case (cls)
            0, 1: begin
                applyStimulus(rb(), rb(), rnd6(), rnd6());
                checkOutput("memadr", ov(0,0,0,0,0,0,0,1,3'b010,2'b00,3'b010,0));
                for (int k = 0; k <= mw; k++) begin
                    applyStimulus(k == mw, rb(), rnd6(), rnd6());
                    checkOutput(cls == 0 ? "memrd" : "memwr",
                                ov(1,1,cls == 1,0,0,0,0,0,3'b000,2'b00,3'b000,0));
                end
                if (cls == 0) begin
                    applyStimulus(rb(), rb(), rnd6(), rnd6());
                    checkOutput("memwb", ov(0,0,0,0,0,1,1,0,3'b000,2'b00,3'b000,0));
                end
                retModel++;
            end
            2: begin
                fa = functAlu(f);
                applyStimulus(rb(), rb(), rnd6(), f);
                checkOutput("rtypeex", ov(0,0,0,0,0,0,0,1,3'b000,2'b00,fa[2:0],0));
                if (fa[3]) illModel = 1'b1;
                applyStimulus(rb(), rb(), rnd6(), rnd6());
                checkOutput("rtypewb", ov(0,0,0,0,1,0,1,0,3'b000,2'b00,3'b000,0));
                retModel++;
            end
            3: begin
                z = (zsel == 0 || zsel == 1) ? bit'(zsel) : rb();
                applyStimulus(rb(), z, rnd6(), rnd6());
                checkOutput(z ? "beqTaken" : "beqNotTaken", ov(0,0,0,0,0,0,0,1,3'b000,2'b01,3'b110,z));
                retModel++;
            end
            4, 5: begin
                applyStimulus(rb(), rb(), o, rnd6());
                if (cls == 5) checkOutput("oriEx", ov(0,0,0,0,0,0,0,1,3'b100,2'b00,3'b001,0));
                else          checkOutput("addiEx", ov(0,0,0,0,0,0,0,1,3'b010,2'b00,3'b010,0));
                applyStimulus(rb(), rb(), rnd6(), rnd6());
                checkOutput("immwb", ov(0,0,0,0,0,0,1,0,3'b000,2'b00,3'b000,0));
                retModel++;
            end
            6: begin
                applyStimulus(rb(), rb(), rnd6(), rnd6());
                checkOutput("jex", ov(0,0,0,0,0,0,0,0,3'b000,2'b10,3'b000,1));
                retModel++;
            end
            default: illModel = 1'b1;
        endcase
    endtask

    initial begin
        int r, cls;

        // Power-on reset: FETCH outputs asynchronously, nothing flagged
        applyStimulus(1'b0, 1'b0, 6'b0, 6'b0);
        #2;
        checks++;
        assert (obsVec === {ov(1,0,0,0,0,0,0,0,3'b001,2'b00,3'b010,0), 1'b0}) else begin
            errors++;
            $error("[TB] FAIL resetState observed=%b", obsVec);
        end
        checkCounters("resetCounters");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Twenty R-type instructions with immediate memory acknowledge: 80 cycles
        for (int i = 0; i < 20; i++) runInstr(2, 0, 0, 2, -1);
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        assert (cyc_cnt === 4'd0) else begin
            errors++;
            $error("[TB] FAIL wrapCyc observed=%0d expected=0", cyc_cnt);
        end
        checks++;
        assert (ret_cnt === 4'd4) else begin
            errors++;
            $error("[TB] FAIL wrapRet observed=%0d expected=4", ret_cnt);
        end
`endif

        // Directed instruction scenarios
        runInstr(0, 0, 0, 2, -1);
        runInstr(1, 0, 3, 2, -1);
        runInstr(3, 0, 0, 1, -1);
        runInstr(3, 0, 0, 0, -1);
        runInstr(2, 0, 0, 2, 6'b101010);
        runInstr(5, 1, 0, 2, -1);
        runInstr(4, 2, 0, 2, -1);
        runInstr(6, 0, 0, 2, -1);

        // Random instruction mix with random acknowledge delays
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            cls = (r < 18) ? (r % 7) : 8;
            runInstr(cls, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                     ($urandom_range(0, 5) == 0) ? -2 : -1);
        end

        // Illegal opcode makes the flag sticky across later instructions
        runInstr(7, 0, 0, 2, -1);
        runInstr(4, 0, 0, 2, -1);

        // Reset asserted in the middle of a load's memory read
        applyStimulus(1'b1, rb(), rnd6(), rnd6());
        checkOutput("rstFetch", ov(1,0,0,1,0,0,0,0,3'b001,2'b00,3'b010,1));
        applyStimulus(rb(), rb(), 6'b100011, rnd6());
        checkOutput("rstDecode", ov(0,0,0,0,0,0,0,0,3'b011,2'b00,3'b010,0));
        applyStimulus(rb(), rb(), rnd6(), rnd6());
        checkOutput("rstMemadr", ov(0,0,0,0,0,0,0,1,3'b010,2'b00,3'b010,0));
        applyStimulus(1'b0, rb(), rnd6(), rnd6());
        checkOutput("rstMemrd", ov(1,1,0,0,0,0,0,0,3'b000,2'b00,3'b000,0));
        #2;
        reset = 1'b0;
        #1;
        illModel = 1'b0;
        cycModel = 0;
        retModel = 0;
        checks++;
        assert (obsVec === {ov(1,0,0,0,0,0,0,0,3'b001,2'b00,3'b010,0), 1'b0}) else begin
            errors++;
            $error("[TB] FAIL asyncReset observed=%b", obsVec);
        end
        checkCounters("asyncResetCounters");
        @(posedge clk);
        #1;
        reset = 1'b1;
        runInstr(0, 0, 0, 2, -1);
        runInstr(1, 2, 1, 2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port op  input  6  instr[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instr[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ack  input  1  memory completion for the current request.
REQ-008 SHALL have port mem_req  output  1  memory access request.
REQ-009 SHALL have ports iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath selects and enables.
REQ-010 SHALL have ports alusrcb  output  3 (000 B, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm); pcsrc  output  2 (00 ALU, 01 ALUOut, 10 jump target); alucontrol  output  3.
REQ-011 SHALL have ports pcen  output  1 and illegal  output  1  sticky illegal-opcode flag.

Function
REQ-012 SHALL implement Moore FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX.
REQ-013 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=001, alucontrol=010, pcsrc=00; holds until mem_ack; with mem_ack=1, irwrite=1, pcwrite=1, next DECODE.
REQ-014 DECODE: alusrca=0, alusrcb=011, alucontrol=010 (branch target into ALUOut); next by op: 100011/101011 MEMADR, 000000 RTYPEEX, 000100 BEQEX, 001000/001101 IMMEX, 000010 JEX, else FETCH with illegal set.
REQ-015 MEMADR: alusrca=1, alusrcb=010, alucontrol=010; next MEMRD for lw, MEMWR for sw.
REQ-016 MEMRD: mem_req=1, iord=1; holds until mem_ack, then MEMWB.
REQ-017 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-018 MEMWR: mem_req=1, iord=1, memwrite=1 for every cycle in state; holds until mem_ack, then FETCH.
REQ-019 RTYPEEX: alusrca=1, alusrcb=000; alucontrol by funct: 100000 010, 100010 110, 100100 000, 100101 001, 101010 111, other 010 with illegal set; next RTYPEWB.
REQ-020 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-021 BEQEX: alusrca=1, alusrcb=000, alucontrol=110, pcsrc=01, branch=1; next FETCH.
REQ-022 IMMEX: alusrca=1; addi alusrcb=010, alucontrol=010; ori alusrcb=100, alucontrol=001; next IMMWB.
REQ-023 IMMWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-024 JEX: pcsrc=10, pcwrite=1; next FETCH.
REQ-025 pcen SHALL equal pcwrite OR (branch AND zero), combinational from state, mem_ack and zero.
REQ-026 All outputs not listed for a state SHALL be 0 in that state.
REQ-027 mem_ack outside FETCH/MEMRD/MEMWR SHALL be ignored; mem_ack in the cycle mem_req rises SHALL complete the access (zero-wait).
REQ-028 illegal SHALL stay 1 until reset once set.
REQ-029 op and funct SHALL be sampled combinationally in DECODE and RTYPEEX/IMMEX only.

Reset
REQ-030 reset=0 SHALL immediately force state FETCH, illegal=0, counters 0, independent of clk.
REQ-031 Reset mid-access SHALL abandon the access; after release, mem_req=1 with iord=0 on the first cycle.

Configuration
REQ-032 Macro MULTICYCLE_CTRL_PERF_EN defined: SHALL add outputs cyc_cnt and ret_cnt (CNT_W each); cyc_cnt increments every cycle out of reset, ret_cnt increments on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, IMMWB or JEX; both wrap modulo 2^CNT_W.
REQ-033 Macro undefined: SHALL have no counter ports or registers; all other behaviour identical.

Verification
REQ-034 lw, mem_ack held 1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB, 5 cycles; regwrite=1, memtoreg=1 in cycle 5.
REQ-035 sw with mem_ack low for 3 cycles in MEMWR: memwrite=1 for 4 cycles, then FETCH; regwrite never 1.
REQ-036 beq, zero=1 in BEQEX: pcen=1, pcsrc=01; repeat with zero=0: pcen=0.
REQ-037 R-type funct=101010: alucontrol=111 in RTYPEEX, regdst=1 in RTYPEWB; ori: alusrcb=100, alucontrol=001.
REQ-038 op=111111: DECODE then FETCH, illegal=1 until reset; reset low mid-MEMRD: FETCH asynchronously, illegal=0.
REQ-039 With MULTICYCLE_CTRL_PERF_EN, CNT_W=4: 20 R-type instructions (80 cycles) -> ret_cnt=4 (wrapped), cyc_cnt=0.
